mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Bus-master counterpart of the memory controller: it accepts one burst command (write or read, start address, length, data seed) and drives the memory's valid/ready, wr_en/rd_en, addr and wdata pins.
- For reads it captures rdata and presp and returns them as a response stream.
- It sits between a test/processor-side command source and the memory controller; one burst is in flight at a time.

Parameters:
MEM_DEPTH, 128, number of memory locations
ADDR_WIDTH, $clog2(MEM_DEPTH), address width
DATA_WIDTH, 8, data word width
LEN_WIDTH, ADDR_WIDTH+1, burst length width (holds 0..MEM_DEPTH)

Ports:
clk_i  in  1  single clock, all logic on posedge
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  high only in IDLE; command accepted on cmd_valid_i & cmd_ready_o
cmd_wr_i  in  1  1 = write burst, 0 = read burst
cmd_addr_i  in  ADDR_WIDTH  start address
cmd_len_i  in  LEN_WIDTH  beats, 0..MEM_DEPTH
cmd_seed_i  in  DATA_WIDTH  write data for beat k = seed + k (mod 2^DATA_WIDTH)
mem_valid_o  out  1  to memory valid_i
mem_ready_i  in  1  from memory ready_o
mem_wr_en_o  out  1  to memory wr_en_i
mem_rd_en_o  out  1  to memory rd_en_i
mem_addr_o  out  ADDR_WIDTH  to memory addr_i
mem_wdata_o  out  DATA_WIDTH  to memory wdata_i
mem_rdata_i  in  DATA_WIDTH  from memory rdata_o
mem_presp_i  in  1  from memory presp_o (address error)
rsp_valid_o  out  1  one-cycle pulse per completed read beat
rsp_addr_o  out  ADDR_WIDTH  address of the returned beat
rsp_data_o  out  DATA_WIDTH  read data
rsp_err_o  out  1  presp seen for this beat
done_o  out  1  one-cycle pulse at burst end
err_cnt_o  out  LEN_WIDTH  presp errors in the last burst; cleared on command accept

Behaviour:
- Reset (rst_ni low, asynchronous) drives every output to 0, sets state to IDLE and clears the internal counters. Asserting reset mid-burst aborts the burst immediately: no done_o, and mem_valid_o drops with no clock edge.
- State machine: IDLE -> REQ -> XFER -> DRAIN -> DONE -> IDLE.
  - IDLE: cmd_ready_o=1. On accept, latch the command. If len=0, go directly to DONE (no memory access); otherwise go to REQ.
  - REQ: mem_valid_o=1 with wr_en=rd_en=0. Stay in REQ until mem_ready_i=1 is sampled.
  - XFER: one beat per cycle.
    - mem_addr_o = (start+k) mod 2^ADDR_WIDTH; the address wraps.
    - Write bursts: wr_en=1 and wdata=seed+k.
    - Read bursts: rd_en=1.
    - k increments each cycle. After beat len-1 is issued, go to DRAIN.
  - DRAIN: mem_valid_o=0, enables 0, for one cycle, so the last beat's registered response is captured.
  - DONE: done_o=1 for one cycle, then return to IDLE.
- Read response latency: a beat issued in cycle n is sampled at the end of cycle n+1 (the memory registers rdata/presp at the issue edge). rsp_valid_o/addr/data/err are then registered, so they are visible in cycle n+2. Beats are returned strictly in order; no backpressure.
- presp: sampled for every beat, write and read, with the same 1-cycle alignment. Each sampled 1 increments err_cnt_o, which saturates at MEM_DEPTH. For reads, rsp_err_o=1 and rsp_data_o is passed through unchanged. An address error does not abort the burst.
- If mem_ready_i drops during XFER, issue continues; ready_i is checked only in REQ.
- cmd_valid_i outside IDLE is ignored (cmd_ready_o=0).
- Memory outputs hold 0 whenever the block is not in REQ or XFER.
- Arithmetic: address and data increments truncate to their widths. len > MEM_DEPTH is clamped to MEM_DEPTH.

Decomposition:
- Shared package mem_pkg holds:
  - the MEM_DEPTH, ADDR_WIDTH, DATA_WIDTH and LEN_WIDTH defaults, shared with memory_ctrl;
  - the state enum {IDLE, REQ, XFER, DRAIN, DONE};
  - the op encoding constants OP_WR=1, OP_RD=0.
- One natural sub-module, mem_rsp_capture: the delay/capture stage that aligns rdata/presp to the issued beat address and produces rsp_* and the error increment.

Test Plan:
- Reset mid-burst: write addr=10, len=8; pull rst_ni low in the 3rd XFER cycle -> all outputs 0 immediately, no done_o; a following read of len=1 works normally.
- Write then read: write addr=1, len=5, seed=0x20, with mem_initiator connected to memory_ctrl -> mem[1..5]=0x20..0x24; read addr=1, len=5 -> 5 rsp pulses in order, addr 1..5, data 0x20..0x24, rsp_err_o=0, err_cnt_o=0, done_o once.
- Address error: read addr=0, len=3 -> beat 0 has rsp_err_o=1, beats 1,2 have err=0, err_cnt_o=1.
- Wrap-around: write addr=126, len=4, seed=0xFE -> addresses 126,127,0,1 with data 0xFE,0xFF,0x00,0x01; err_cnt_o=1 from addr 0.
- Zero length: cmd_len_i=0 -> mem_valid_o never asserted, done_o pulses 2 cycles after accept.
- Ready stall: memory model holds ready low for 4 cycles -> initiator stays in REQ with enables low, no beats lost; first beat follows the cycle ready is sampled high.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller and its bus-master initiator.
package mem_pkg;

  localparam int DEF_MEM_DEPTH  = 128;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_MEM_DEPTH);
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = DEF_ADDR_WIDTH + 1;

  // Operation encoding of the command write flag
  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mem_rsp_capture.sv
// Aligns the registered memory response (rdata/presp) with the beat that
// produced it and emits one read response per beat plus an error increment.
module mem_rsp_capture
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  beat_vld_i,
  input  logic                  beat_rd_i,
  input  logic [ADDR_WIDTH-1:0] beat_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_presp_i,
  output logic                  rsp_valid_o,
  output logic [ADDR_WIDTH-1:0] rsp_addr_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  err_inc_o
);

  logic                  vld_p0;
  logic                  rd_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;

  // ---- stage p0: beat issued last cycle; memory response arrives now ----
  // Control of the issued beat, delayed to meet the memory's registered reply
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0 <= 1'b0;
      rd_p0  <= 1'b0;
    end else begin
      vld_p0 <= beat_vld_i;
      rd_p0  <= beat_rd_i;
    end
  end

  // Beat address travels alongside the control bits, no reset needed
  always_ff @(posedge clk_i) begin
    addr_p0 <= beat_addr_i;
  end

  // Any beat, read or write, whose reply flags an address error
  assign err_inc_o = vld_p0 & mem_presp_i;

  // ---- stage p1: registered response stream ----
  // One response per read beat; data passes through even on an address error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_addr_o  <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= vld_p0 & rd_p0;
      rsp_err_o   <= vld_p0 & rd_p0 & mem_presp_i;
      if (vld_p0 && rd_p0) begin
        rsp_addr_o <= addr_p0;
        rsp_data_o <= mem_rdata_i;
      end
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Bus master for the memory controller: runs one write or read burst per
// command, generating addresses start+k and write data seed+k.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [DATA_WIDTH-1:0] cmd_seed_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_presp_i,
  output logic                  rsp_valid_o,
  output logic [ADDR_WIDTH-1:0] rsp_addr_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  err_cnt_o
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MEM_DEPTH);

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  accept;
  logic                  beat_vld;
  logic                  err_inc;

  // Bursts longer than the memory are cut to one full pass
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  // Error counter stops at the largest possible number of beats
  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] cnt);
    return (cnt >= MAX_LEN) ? cnt : cnt + 1'b1;
  endfunction

  assign accept   = (state_q == IDLE) && cmd_ready_o && cmd_valid_i;
  assign beat_vld = mem_valid_o & (mem_wr_en_o | mem_rd_en_o);

  // Command fields held for the whole burst
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wr_q   <= cmd_wr_i;
      addr_q <= cmd_addr_i;
      seed_q <= cmd_seed_i;
    end
  end

  // Burst sequencer; outputs are registered alongside the state they belong to
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      cmd_ready_o <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_wr_en_o <= 1'b0;
      mem_rd_en_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_ready_o && cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            rem_q       <= clamp_len(cmd_len_i);
            if (clamp_len(cmd_len_i) == '0) begin
              state_q <= DONE;
            end else begin
              state_q     <= REQ;
              mem_valid_o <= 1'b1;
            end
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ready_i) begin
            state_q     <= XFER;
            mem_wr_en_o <= (wr_q == OP_WR);
            mem_rd_en_o <= (wr_q == OP_RD);
            mem_addr_o  <= addr_q;
            mem_wdata_o <= (wr_q == OP_WR) ? seed_q : '0;
          end
        end
        XFER: begin
          if (rem_q == LEN_WIDTH'(1)) begin
            state_q     <= DRAIN;
            mem_valid_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            mem_rd_en_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
          end else begin
            rem_q      <= rem_q - 1'b1;
            mem_addr_o <= mem_addr_o + 1'b1;
            if (wr_q == OP_WR) begin
              mem_wdata_o <= mem_wdata_o + 1'b1;
            end
          end
        end
        DRAIN: begin
          state_q <= DONE;
        end
        DONE: begin
          state_q     <= IDLE;
          done_o      <= 1'b1;
          cmd_ready_o <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Address errors of the current burst, restarted by each new command
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
    end else if (accept) begin
      err_cnt_o <= '0;
    end else if (err_inc) begin
      err_cnt_o <= sat_inc(err_cnt_o);
    end
  end

  mem_rsp_capture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_capture (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .beat_vld_i  (beat_vld),
    .beat_rd_i   (mem_rd_en_o),
    .beat_addr_i (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_presp_i (mem_presp_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_addr_o  (rsp_addr_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .err_inc_o   (err_inc)
  );

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a small registered memory model.
module tb_mem_initiator;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready_o;
  logic       cmd_wr;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [7:0] cmd_seed;
  logic       mem_valid_o;
  logic       mem_ready;
  logic       mem_wr_en_o;
  logic       mem_rd_en_o;
  logic [6:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata;
  logic       mem_presp;
  logic       rsp_valid_o;
  logic [6:0] rsp_addr_o;
  logic [7:0] rsp_data_o;
  logic       rsp_err_o;
  logic       done_o;
  logic [7:0] err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [128];

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] len;
    logic [7:0] seed;
    int         beats;
    int         err;
  } vec_t;

  vec_t vecs [10];

  mem_initiator dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_wr_i    (cmd_wr),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .cmd_seed_i  (cmd_seed),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_rd_en_o (mem_rd_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata),
    .mem_presp_i (mem_presp),
    .rsp_valid_o (rsp_valid_o),
    .rsp_addr_o  (rsp_addr_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .done_o      (done_o),
    .err_cnt_o   (err_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: registered rdata/presp, address 0 is an error and not writable
  initial begin
    logic [7:0] mem_model [128];
    for (int i = 0; i < 128; i++) mem_model[i] = 8'h5A;
    mem_rdata = 8'h00;
    mem_presp = 1'b0;
    forever begin
      @(posedge clk);
      mem_presp <= mem_valid_o && (mem_wr_en_o || mem_rd_en_o) && (mem_addr_o == 7'd0);
      if (mem_valid_o && mem_rd_en_o) mem_rdata <= mem_model[mem_addr_o];
      if (mem_valid_o && mem_wr_en_o && mem_addr_o != 7'd0) mem_model[mem_addr_o] <= mem_wdata_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {19'd0, cmd_ready_o, mem_valid_o, mem_wr_en_o, mem_rd_en_o, mem_addr_o, mem_wdata_o,
            rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_err_o, done_o, err_cnt_o};
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic issue_cmd(input logic wr, input logic [6:0] a, input logic [7:0] l, input logic [7:0] s);
    int n = 0;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 64'(cmd_ready_o), 64'd1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_seed  = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input int id, input vec_t v);
    int wr_idx = 0;
    int rd_idx = 0;
    int rsp_idx = 0;
    int done_cnt = 0;
    int vld_cnt = 0;
    int after = -1;
    int cyc = 0;
    logic [6:0] ea;
    issue_cmd(v.wr, v.addr, v.len, v.seed);
    while (after < 2 && cyc < 400) begin
      if (mem_valid_o) vld_cnt++;
      if (mem_valid_o && mem_wr_en_o) begin
        ea = v.addr + 7'(wr_idx);
        check($sformatf("v%0d_wr_addr%0d", id, wr_idx), 64'(mem_addr_o), 64'(ea));
        check($sformatf("v%0d_wr_data%0d", id, wr_idx), 64'(mem_wdata_o), 64'(8'(v.seed + 8'(wr_idx))));
        wr_idx++;
      end
      if (mem_valid_o && mem_rd_en_o) begin
        ea = v.addr + 7'(rd_idx);
        check($sformatf("v%0d_rd_addr%0d", id, rd_idx), 64'(mem_addr_o), 64'(ea));
        rd_idx++;
      end
      if (rsp_valid_o) begin
        ea = v.addr + 7'(rsp_idx);
        check($sformatf("v%0d_rsp_addr%0d", id, rsp_idx), 64'(rsp_addr_o), 64'(ea));
        check($sformatf("v%0d_rsp_data%0d", id, rsp_idx), 64'(rsp_data_o), 64'(ref_mem[ea]));
        check($sformatf("v%0d_rsp_err%0d", id, rsp_idx), 64'(rsp_err_o), 64'(ea == 7'd0));
        rsp_idx++;
      end
      if (done_o) done_cnt++;
      if (done_cnt > 0) after++;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d_timeout", id), 64'(cyc < 400), 64'd1);
    check($sformatf("v%0d_wr_beats", id), 64'(wr_idx), 64'(v.wr ? v.beats : 0));
    check($sformatf("v%0d_rd_beats", id), 64'(rd_idx), 64'(v.wr ? 0 : v.beats));
    check($sformatf("v%0d_rsp_count", id), 64'(rsp_idx), 64'(v.wr ? 0 : v.beats));
    check($sformatf("v%0d_valid_cycles", id), 64'(vld_cnt), 64'(v.beats == 0 ? 0 : v.beats + 1));
    check($sformatf("v%0d_done_count", id), 64'(done_cnt), 64'd1);
    check($sformatf("v%0d_err_cnt", id), 64'(err_cnt_o), 64'(v.err));
    if (v.wr) begin
      for (int k = 0; k < v.beats; k++) begin
        ea = v.addr + 7'(k);
        if (ea != 7'd0) ref_mem[ea] = v.seed + 8'(k);
      end
    end
  endtask

  initial begin
    int n;
    vec_t rv;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h5A;
    //            wr    addr     len      seed    beats err
    vecs[0] = '{1'b1, 7'd1,   8'd5,   8'h20, 5,   0};
    vecs[1] = '{1'b0, 7'd1,   8'd5,   8'h00, 5,   0};
    vecs[2] = '{1'b0, 7'd0,   8'd3,   8'h00, 3,   1};
    vecs[3] = '{1'b1, 7'd126, 8'd4,   8'hFE, 4,   1};
    vecs[4] = '{1'b0, 7'd126, 8'd4,   8'h00, 4,   1};
    vecs[5] = '{1'b1, 7'd40,  8'd0,   8'h33, 0,   0};
    vecs[6] = '{1'b1, 7'd100, 8'd200, 8'h00, 128, 1};
    vecs[7] = '{1'b0, 7'd5,   8'd2,   8'h00, 2,   0};
    vecs[8] = '{1'b1, 7'd127, 8'd1,   8'h99, 1,   0};
    vecs[9] = '{1'b0, 7'd127, 8'd2,   8'h00, 2,   1};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_seed  = '0;
    mem_ready = 1'b1;
    #3;
    check("reset_outputs", all_outputs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);

    // Reset in the third XFER cycle of a write burst
    issue_cmd(1'b1, 7'd10, 8'd8, 8'h70);
    n = 0;
    while (!mem_wr_en_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_first_beat_seen", 64'(mem_wr_en_o), 64'd1);
    repeat (2) @(negedge clk);
    check("abort_third_beat_addr", 64'(mem_addr_o), 64'd12);
    #1 rst_n = 1'b0;
    #1 check("abort_outputs_zero", all_outputs(), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done_o), 64'd0);
      check("abort_mem_valid", 64'(mem_valid_o), 64'd0);
    end
    rst_n = 1'b1;
    ref_mem[10] = 8'h70;
    ref_mem[11] = 8'h71;
    @(negedge clk);
    rv = '{1'b0, 7'd10, 8'd1, 8'h00, 1, 0};
    run_burst(99, rv);

    for (int i = 0; i < 10; i++) run_burst(i, vecs[i]);

    // Zero length: done two cycles after the accepting cycle, no memory access
    issue_cmd(1'b0, 7'd3, 8'd0, 8'h00);
    check("zl_done_early", 64'(done_o), 64'd0);
    check("zl_no_valid_a", 64'(mem_valid_o), 64'd0);
    @(negedge clk);
    check("zl_done_pulse", 64'(done_o), 64'd1);
    check("zl_no_valid_b", 64'(mem_valid_o), 64'd0);
    @(negedge clk);
    check("zl_done_once", 64'(done_o), 64'd0);

    // Ready held low for four cycles in REQ, then dropped again during XFER
    mem_ready = 1'b0;
    issue_cmd(1'b0, 7'd1, 8'd2, 8'h00);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("stall_valid%0d", c), 64'(mem_valid_o), 64'd1);
      check($sformatf("stall_enables%0d", c), 64'({mem_wr_en_o, mem_rd_en_o}), 64'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("stall_beat0_rd", 64'(mem_rd_en_o), 64'd1);
    check("stall_beat0_addr", 64'(mem_addr_o), 64'd1);
    mem_ready = 1'b0;
    @(negedge clk);
    check("stall_beat1_rd", 64'(mem_rd_en_o), 64'd1);
    check("stall_beat1_addr", 64'(mem_addr_o), 64'd2);
    @(negedge clk);
    check("stall_drain_valid", 64'(mem_valid_o), 64'd0);
    check("stall_rsp0", 64'({rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_err_o}),
          64'({1'b1, 7'd1, ref_mem[1], 1'b0}));
    @(negedge clk);
    check("stall_rsp1", 64'({rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_err_o}),
          64'({1'b1, 7'd2, ref_mem[2], 1'b0}));
    check("stall_no_done_yet", 64'(done_o), 64'd0);
    @(negedge clk);
    check("stall_done", 64'(done_o), 64'd1);
    check("stall_rsp_end", 64'(rsp_valid_o), 64'd0);
    check("stall_err_cnt", 64'(err_cnt_o), 64'd0);
    mem_ready = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
